alu_exec_stage: RTL and testbench



---
 rtl/alu_exec_stage.sv | 116 +++++++++++
 tb/tb_alu_exec_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Registered RV32I ALU execute stage with a one-entry skid buffer.
// Optional operand forwarding from the output register: define ALU_EXEC_FWD_EN.
module alu_exec_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [4:0]  in_rd_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd_addr,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd_addr;
        logic        illegal;
    } entry_t;

    entry_t or_q, sk_q, or_nxt, sk_nxt, in_ent;
    logic   or_vld, sk_vld, or_vld_nxt, sk_vld_nxt, rdy_q;
    logic   acc, or_free;
    logic [31:0] op_a, op_b, alu_res;
    logic        alu_ill;

`ifdef ALU_EXEC_FWD_EN
    // SK is always empty when an input is accepted, so OR holds the youngest older result.
    assign op_a = (or_vld && in_rs1_addr != 5'd0 && in_rs1_addr == or_q.rd_addr) ? or_q.result : in_rs1;
    assign op_b = (or_vld && in_rs2_addr != 5'd0 && in_rs2_addr == or_q.rd_addr) ? or_q.result : in_rs2;
`else
    logic unused_addr;
    assign unused_addr = ^{in_rs1_addr, in_rs2_addr};
    assign op_a = in_rs1;
    assign op_b = in_rs2;
`endif

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (in_op)
            4'b0000: alu_res = op_a + op_b;
            4'b1000: alu_res = op_a - op_b;
            4'b0001: alu_res = op_a << op_b[4:0];
            4'b0010: alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            4'b0011: alu_res = {31'b0, op_a < op_b};
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = op_a >> op_b[4:0];
            4'b1101: alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            4'b0110: alu_res = op_a | op_b;
            4'b0111: alu_res = op_a & op_b;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        in_ent         = '0;
        in_ent.result  = alu_res;
        in_ent.rd_addr = in_rd_addr;
        in_ent.illegal = alu_ill;
    end

    assign acc     = in_valid && rdy_q;
    assign or_free = !or_vld || out_ready;

    always_comb begin
        or_nxt     = or_q;
        sk_nxt     = sk_q;
        or_vld_nxt = or_vld;
        sk_vld_nxt = sk_vld;
        if (or_free) begin
            if (sk_vld) begin
                // SK is older than any new input, so it moves up first.
                or_nxt     = sk_q;
                or_vld_nxt = 1'b1;
                sk_vld_nxt = acc;
                if (acc) sk_nxt = in_ent;
            end else begin
                or_vld_nxt = acc;
                if (acc) or_nxt = in_ent;
            end
        end else if (acc) begin
            sk_nxt     = in_ent;
            sk_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_q   <= '0;
            sk_q   <= '0;
            or_vld <= 1'b0;
            sk_vld <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            or_q   <= or_nxt;
            sk_q   <= sk_nxt;
            or_vld <= or_vld_nxt;
            sk_vld <= sk_vld_nxt;
            rdy_q  <= !sk_vld_nxt;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = or_vld;
    assign out_result  = or_q.result;
    assign out_rd_addr = or_q.rd_addr;
    assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_rs1 = '0, in_rs2 = '0;
    logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd_addr;
    logic        out_illegal;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_exec_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd_addr(out_rd_addr), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
        in_valid = v; in_op = op; in_rs1 = a; in_rs2 = b;
        in_rd_addr = rd; in_rs1_addr = a1; in_rs2_addr = a2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_result !== 32'h0) $display("FAIL reset_result got %h exp 0", out_result); else pass_cnt++;
        total_cnt++; if (out_rd_addr !== 5'd0) $display("FAIL reset_rd got %0d exp 0", out_rd_addr); else pass_cnt++;
        total_cnt++; if (out_illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", out_illegal); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b exp 1", in_ready); else pass_cnt++;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, exp;
        logic        ill;
    } vec_t;

    task automatic test_alu_ops();
        vec_t v[14];
        v[0]  = '{4'b1000, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0}; // SUB
        v[1]  = '{4'b1101, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0}; // SRA by 4
        v[2]  = '{4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0}; // SLT -1<1
        v[3]  = '{4'b0010, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0}; // SLT 1<-1
        v[4]  = '{4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0}; // SLTU
        v[5]  = '{4'b1001, 32'd3,         32'd4,         32'd0,         1'b1}; // illegal
        v[6]  = '{4'b0000, 32'd2,         32'd2,         32'd4,         1'b0}; // ADD
        v[7]  = '{4'b0000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0}; // ADD wrap
        v[8]  = '{4'b0001, 32'd1,         32'h21,        32'd2,         1'b0}; // SLL, rs2[31:5] ignored
        v[9]  = '{4'b0101, 32'h8000_0000, 32'd31,        32'd1,         1'b0}; // SRL
        v[10] = '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0}; // XOR
        v[11] = '{4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0}; // OR
        v[12] = '{4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0}; // AND
        v[13] = '{4'b1111, 32'd9,         32'd9,         32'd0,         1'b1}; // illegal
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, v[i].op, v[i].a, v[i].b, 5'(i + 3), 5'd0, 5'd0);
            tick();
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL alu%0d_valid got %b exp 1", i, out_valid); else pass_cnt++;
            total_cnt++; if (out_result !== v[i].exp) $display("FAIL alu%0d_result got %h exp %h", i, out_result, v[i].exp); else pass_cnt++;
            total_cnt++; if (out_rd_addr !== 5'(i + 3)) $display("FAIL alu%0d_rd got %0d exp %0d", i, out_rd_addr, i + 3); else pass_cnt++;
            total_cnt++; if (out_illegal !== v[i].ill) $display("FAIL alu%0d_illegal got %b exp %b", i, out_illegal, v[i].ill); else pass_cnt++;
        end
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL alu_idle_valid got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 32'd10, 32'd0, 5'd1, 5'd0, 5'd0); // A = 10
        tick();
        total_cnt++; if (out_result !== 32'd10 || out_valid !== 1'b1) $display("FAIL b2b_A_in_or got %h/%b exp 0000000a/1", out_result, out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_A got %b exp 1", in_ready); else pass_cnt++;
        drive(1'b1, 4'b0000, 32'd20, 32'd0, 5'd2, 5'd0, 5'd0); // B = 20
        tick();
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_full got %b exp 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_result !== 32'd10 || out_rd_addr !== 5'd1) $display("FAIL b2b_A_held got %h/%0d exp 0000000a/1", out_result, out_rd_addr); else pass_cnt++;
        drive(1'b1, 4'b0000, 32'd30, 32'd0, 5'd3, 5'd0, 5'd0); // C = 30, must wait
        tick(); tick();
        total_cnt++; if (out_result !== 32'd10 || out_valid !== 1'b1) $display("FAIL b2b_A_stable got %h/%b exp 0000000a/1", out_result, out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_stays_low got %b exp 0", in_ready); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (out_result !== 32'd20 || out_rd_addr !== 5'd2) $display("FAIL b2b_B_out got %h/%0d exp 00000014/2", out_result, out_rd_addr); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_release got %b exp 1", in_ready); else pass_cnt++;
        tick();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        total_cnt++; if (out_result !== 32'd30 || out_rd_addr !== 5'd3 || out_valid !== 1'b1) $display("FAIL b2b_C_out got %h/%0d/%b exp 0000001e/3/1", out_result, out_rd_addr, out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_no_dup got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 32'd7, 32'd0, 5'd4, 5'd0, 5'd0);
        tick(); tick();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rmid_full got %b exp 0", in_ready); else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rmid_in_ready got %b exp 0", in_ready); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rmid_release_ready got %b exp 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_empty got %b exp 0", out_valid); else pass_cnt++;
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 32'd1, 32'd1, 5'd6, 5'd0, 5'd0);
        tick();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        total_cnt++; if (out_result !== 32'd2 || out_valid !== 1'b1) $display("FAIL rmid_add got %h/%b exp 00000002/1", out_result, out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_skid_cleared got %b exp 0", out_valid); else pass_cnt++;
    endtask

    // Hold a producer in OR, then issue a consumer naming its register.
    task automatic fwd_case(input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp, input string name);
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 32'd4, 32'd6, rd, 5'd0, 5'd0);
        tick();
        drive(1'b1, 4'b0000, r1, r2, 5'd9, a1, a2);
        tick();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        out_ready = 1'b1;
        total_cnt++; if (out_result !== 32'd10) $display("FAIL %s_producer got %h exp 0000000a", name, out_result); else pass_cnt++;
        tick();
        total_cnt++; if (out_result !== exp) $display("FAIL %s_result got %h exp %h", name, out_result, exp); else pass_cnt++;
        tick();
    endtask

    task automatic test_forwarding();
`ifdef ALU_EXEC_FWD_EN
        fwd_case(5'd5, 5'd5, 5'd0, 32'd0, 32'd1, 32'd11, "fwd_rs1");
        fwd_case(5'd5, 5'd0, 5'd5, 32'd1, 32'd0, 32'd11, "fwd_rs2");
`else
        fwd_case(5'd5, 5'd5, 5'd0, 32'd0, 32'd1, 32'd1, "nofwd_rs1");
        fwd_case(5'd5, 5'd0, 5'd5, 32'd1, 32'd0, 32'd1, "nofwd_rs2");
`endif
        fwd_case(5'd0, 5'd0, 5'd0, 32'd0, 32'd1, 32'd1, "fwd_x0");
        // Producer already drained: the consumer uses its own operand.
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 32'd0, 32'd1, 5'd8, 5'd9, 5'd0);
        tick();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        total_cnt++; if (out_result !== 32'd1) $display("FAIL fwd_drained got %h exp 00000001", out_result); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_reset_mid();
        test_forwarding();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
